// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit for a LEGv8-style datapath.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per instruction and
// drives the datapath controls from an instruction class registered in DECODE.
//
// Handshake: imem_ready / dmem_ready are completion strobes. The access owned
// by the current state (instruction fetch in FETCH, MemRead/MemWrite in MEM)
// stays requested every cycle until the matching ready is high on a rising
// edge. A ready seen in any other state has no effect.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        WRegLoc,
    output logic        ALUSrc,
    output logic        SregUp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUOp,
    output logic [2:0]  BranchOp,
    output logic [1:0]  MemtoReg,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [2:0]  state,
    output logic        halt
);

    localparam logic [2:0] S_FETCH  = 3'b000;
    localparam logic [2:0] S_DECODE = 3'b001;
    localparam logic [2:0] S_EXEC   = 3'b010;
    localparam logic [2:0] S_MEM    = 3'b011;
    localparam logic [2:0] S_WB     = 3'b100;
    localparam logic [2:0] S_HALT   = 3'b111;

    // Instruction classes held between DECODE and the end of the instruction.
    localparam logic [3:0] C_NONE  = 4'd0;
    localparam logic [3:0] C_R     = 4'd1;
    localparam logic [3:0] C_RS    = 4'd2;
    localparam logic [3:0] C_I     = 4'd3;
    localparam logic [3:0] C_LDUR  = 4'd4;
    localparam logic [3:0] C_STUR  = 4'd5;
    localparam logic [3:0] C_CBZ   = 4'd6;
    localparam logic [3:0] C_CBNZ  = 4'd7;
    localparam logic [3:0] C_B     = 4'd8;
    localparam logic [3:0] C_BL    = 4'd9;
    localparam logic [3:0] C_BCOND = 4'd10;
    localparam logic [3:0] C_MOVK  = 4'd11;
    localparam logic [3:0] C_ILL   = 4'd15;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [3:0] cls_q;
    logic [3:0] cls_dec;
    logic       cls_branch;
    logic       active;

    function automatic logic [3:0] classify(input logic [10:0] op);
        casez (op)
            11'b10001011000: return C_R;     // ADD
            11'b11001011000: return C_R;     // SUB
            11'b10001010000: return C_R;     // AND
            11'b10101010000: return C_R;     // ORR
            11'b10101011000: return C_RS;    // ADDS
            11'b11101011000: return C_RS;    // SUBS
            11'b1001000100?: return C_I;     // ADDI
            11'b1101000100?: return C_I;     // SUBI
            11'b11111000010: return C_LDUR;
            11'b11111000000: return C_STUR;
            11'b10110100???: return C_CBZ;
            11'b10110101???: return C_CBNZ;
            11'b000101?????: return C_B;
            11'b100101?????: return C_BL;
            11'b01010100???: return C_BCOND;
            11'b111100101??: return C_MOVK;
            default:         return C_ILL;
        endcase
    endfunction

    assign cls_dec    = classify(opcode);
    // BL is excluded: it retires through WB to write the link register.
    assign cls_branch = (cls_q == C_B) || (cls_q == C_CBZ) ||
                        (cls_q == C_CBNZ) || (cls_q == C_BCOND);
    assign active     = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
    assign state      = state_q;

    // Next-state selection; unused encodings fall into HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = (cls_dec == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (cls_branch)                                state_d = S_FETCH;
                else if ((cls_q == C_LDUR) || (cls_q == C_STUR)) state_d = S_MEM;
                else                                           state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready) state_d = (cls_q == C_STUR) ? S_FETCH : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // State register and class register; class is captured in DECODE only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)     cls_q <= cls_dec;
            else if (state_q == S_FETCH) cls_q <= C_NONE;
        end
    end

    // Output decode from state and registered class.
    always_comb begin
        RegWrite = 1'b0;
        Reg2Loc  = 1'b0;
        WRegLoc  = 1'b0;
        ALUSrc   = 1'b0;
        SregUp   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = 2'b00;
        BranchOp = 3'b000;
        MemtoReg = 2'b00;
        PCWrite  = 1'b0;
        halt     = (state_q == S_HALT);
        // Gated by rst_n so a ready held high during reset cannot leak through.
        IRWrite  = rst_n && (state_q == S_FETCH) && imem_ready;

        if (active) begin
            case (cls_q)
                C_R, C_RS: ALUOp = 2'b10;
                C_I:       begin ALUOp = 2'b11; ALUSrc = 1'b1; end
                C_LDUR:    begin ALUSrc = 1'b1; MemtoReg = 2'b01; end
                C_STUR:    begin ALUSrc = 1'b1; Reg2Loc = 1'b1; end
                C_CBZ:     begin ALUOp = 2'b01; Reg2Loc = 1'b1; BranchOp = 3'b010; end
                C_CBNZ:    begin ALUOp = 2'b01; Reg2Loc = 1'b1; BranchOp = 3'b011; end
                C_B:       begin ALUOp = 2'b01; BranchOp = 3'b001; end
                C_BL:      begin ALUOp = 2'b01; WRegLoc = 1'b1; BranchOp = 3'b001; MemtoReg = 2'b10; end
                C_BCOND:   begin ALUOp = 2'b01; BranchOp = 3'b100; end
                C_MOVK:    begin ALUOp = 2'b01; Reg2Loc = 1'b1; MemtoReg = 2'b11; end
                default:   ;
            endcase
        end

        case (state_q)
            S_EXEC: begin
                SregUp  = (cls_q == C_RS);
                PCWrite = cls_branch;
            end
            S_MEM: begin
                MemRead  = (cls_q == C_LDUR);
                MemWrite = (cls_q == C_STUR);
                PCWrite  = (cls_q == C_STUR) && dmem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
